// File: rtl/nmi_xbar_pkg.sv
// Shared types and default region map for the 1-master to N-slave NMI decoder.
// The default table targets the peripheral subsystem memory map.
package nmi_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        ERR_RSP = 2'd2
    } state_e;

    typedef enum logic {
        CAUSE_UNMAPPED = 1'b0,
        CAUSE_TIMEOUT  = 1'b1
    } err_cause_e;

    localparam int DEF_SLV_NUM = 7;
    localparam int DEF_RGN_NUM = 9;
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

    // Listed highest region first: element [0] is the rightmost entry.
    localparam logic [DEF_RGN_NUM-1:0][31:0] DEF_RGN_BASE = {
        32'h1000_6000, 32'h5000_0000, 32'h1000_5000, 32'h4000_0000, 32'h1000_4000,
        32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000
    };

    localparam logic [DEF_RGN_NUM-1:0][31:0] DEF_RGN_MASK = {
        32'hFF00_FF00, 32'hFF00_0000, 32'hFF00_FF00, 32'hFF00_0000, 32'hFF00_FF00,
        32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00
    };

    localparam logic [DEF_RGN_NUM-1:0][7:0] DEF_RGN_SLV = {
        8'd6, 8'd5, 8'd5, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nmi_addr_dec.sv
// Combinational region match with lowest-index priority; returns {hit, slave index}.
// Kept standalone so a later multi-master arbiter can reuse it per master.
module nmi_addr_dec
    import nmi_xbar_pkg::*;
#(
    parameter int                           RGN_NUM  = DEF_RGN_NUM,
    parameter int                           IDX_W    = 3,
    parameter logic [RGN_NUM-1:0][31:0]     RGN_BASE = DEF_RGN_BASE,
    parameter logic [RGN_NUM-1:0][31:0]     RGN_MASK = DEF_RGN_MASK,
    parameter logic [RGN_NUM-1:0][7:0]      RGN_SLV  = DEF_RGN_SLV
) (
    input  logic [31:0]      addr_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] slv_idx_o
);

    // Scanning downwards lets the lowest matching region overwrite the rest.
    always_comb begin
        hit_o     = 1'b0;
        slv_idx_o = '0;
        for (int r = RGN_NUM - 1; r >= 0; r--) begin
            if (((addr_i ^ RGN_BASE[r]) & RGN_MASK[r]) == 32'd0) begin
                hit_o     = 1'b1;
                slv_idx_o = RGN_SLV[r][IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/nmi_xbar_dec.sv
// 1-master to N-slave NMI decoder with registered slave select, error response
// for unmapped addresses, per-access timeout and captured error address.
module nmi_xbar_dec
    import nmi_xbar_pkg::*;
#(
    parameter int                       SLV_NUM     = DEF_SLV_NUM,
    parameter int                       RGN_NUM     = DEF_RGN_NUM,
    parameter logic [RGN_NUM-1:0][31:0] RGN_BASE    = DEF_RGN_BASE,
    parameter logic [RGN_NUM-1:0][31:0] RGN_MASK    = DEF_RGN_MASK,
    parameter logic [RGN_NUM-1:0][7:0]  RGN_SLV     = DEF_RGN_SLV,
    parameter int                       TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter logic [31:0]              ERR_RDATA   = DEF_ERR_RDATA
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    mst_valid_i,
    input  logic [31:0]             mst_addr_i,
    input  logic [31:0]             mst_wdata_i,
    input  logic [3:0]              mst_wstrb_i,
    output logic [31:0]             mst_rdata_o,
    output logic                    mst_ready_o,
    output logic [SLV_NUM-1:0]      slv_valid_o,
    output logic [31:0]             slv_addr_o,
    output logic [31:0]             slv_wdata_o,
    output logic [3:0]              slv_wstrb_o,
    input  logic [SLV_NUM*32-1:0]   slv_rdata_i,
    input  logic [SLV_NUM-1:0]      slv_ready_i,
    output logic                    err_o,
    output logic [31:0]             err_addr_o,
    output logic                    err_cause_o,
    output logic [1:0]              dbg_state_o
);

    localparam int IDX_W = idx_width(SLV_NUM);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      err_addr_q, err_addr_d;
    err_cause_e       err_cause_q, err_cause_d;

    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic             sel_ready;
    logic [31:0]      sel_rdata;

    nmi_addr_dec #(
        .RGN_NUM  (RGN_NUM),
        .IDX_W    (IDX_W),
        .RGN_BASE (RGN_BASE),
        .RGN_MASK (RGN_MASK),
        .RGN_SLV  (RGN_SLV)
    ) u_addr_dec (
        .addr_i    (mst_addr_i),
        .hit_o     (dec_hit),
        .slv_idx_o (dec_idx)
    );

    // Request is a broadcast; only the selected slave sees valid.
    assign slv_addr_o  = mst_addr_i;
    assign slv_wdata_o = mst_wdata_i;
    assign slv_wstrb_o = mst_wstrb_i;
    assign err_addr_o  = err_addr_q;
    assign err_cause_o = err_cause_q;
    assign dbg_state_o = state_q;

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < SLV_NUM; k++) begin
            if (sel_q == IDX_W'(k)) begin
                sel_ready = slv_ready_i[k];
                sel_rdata = slv_rdata_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;
        slv_valid_o = '0;
        mst_ready_o = 1'b0;
        mst_rdata_o = '0;
        err_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (mst_valid_i) begin
                    if (dec_hit) begin
                        sel_d   = dec_idx;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        err_addr_d  = mst_addr_i;
                        err_cause_d = CAUSE_UNMAPPED;
                        state_d     = ERR_RSP;
                    end
                end
            end
            BUSY: begin
                for (int k = 0; k < SLV_NUM; k++) begin
                    slv_valid_o[k] = (sel_q == IDX_W'(k));
                end
                // A ready on the final timeout cycle still completes normally.
                if (sel_ready) begin
                    mst_ready_o = 1'b1;
                    mst_rdata_o = sel_rdata;
                    state_d     = IDLE;
                end else begin
                    if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
                        err_addr_d  = mst_addr_i;
                        err_cause_d = CAUSE_TIMEOUT;
                        state_d     = ERR_RSP;
                    end
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ERR_RSP: begin
                mst_ready_o = 1'b1;
                mst_rdata_o = ERR_RDATA;
                err_o       = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            err_addr_q  <= '0;
            err_cause_q <= CAUSE_UNMAPPED;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            err_addr_q  <= err_addr_d;
            err_cause_q <= err_cause_d;
        end
    end

endmodule

// File: tb/tb_nmi_xbar_dec.sv
// Directed plus randomized bench for nmi_xbar_dec with a timeout of 16 cycles;
// expectations come from a region-table model and per-access latency rules.
module tb_nmi_xbar_dec;

    localparam int SLV = 7;
    localparam int TMO = 16;
    localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                mst_valid = 1'b0;
    logic [31:0]         mst_addr = '0;
    logic [31:0]         mst_wdata = '0;
    logic [3:0]          mst_wstrb = '0;
    logic [31:0]         mst_rdata;
    logic                mst_ready;
    logic [SLV-1:0]      slv_valid;
    logic [31:0]         slv_addr;
    logic [31:0]         slv_wdata;
    logic [3:0]          slv_wstrb;
    logic [SLV*32-1:0]   slv_rdata = '0;
    logic [SLV-1:0]      slv_ready = '0;
    logic                err;
    logic [31:0]         err_addr;
    logic                err_cause;
    logic [1:0]          dbg_state;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_err_addr = '0;
    logic        exp_err_cause = 1'b0;

    int unsigned rgn_base[9] = '{32'h1000_0000, 32'h1000_1000, 32'h1000_2000, 32'h1000_3000,
                                 32'h1000_4000, 32'h4000_0000, 32'h1000_5000, 32'h5000_0000,
                                 32'h1000_6000};
    int unsigned rgn_mask[9] = '{32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00,
                                 32'hFF00_FF00, 32'hFF00_0000, 32'hFF00_FF00, 32'hFF00_0000,
                                 32'hFF00_FF00};
    int rgn_slv[9] = '{0, 1, 2, 3, 4, 4, 5, 5, 6};

    nmi_xbar_dec #(.TIMEOUT_CYC(TMO)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .mst_valid_i (mst_valid),
        .mst_addr_i  (mst_addr),
        .mst_wdata_i (mst_wdata),
        .mst_wstrb_i (mst_wstrb),
        .mst_rdata_o (mst_rdata),
        .mst_ready_o (mst_ready),
        .slv_valid_o (slv_valid),
        .slv_addr_o  (slv_addr),
        .slv_wdata_o (slv_wdata),
        .slv_wstrb_o (slv_wstrb),
        .slv_rdata_i (slv_rdata),
        .slv_ready_i (slv_ready),
        .err_o       (err),
        .err_addr_o  (err_addr),
        .err_cause_o (err_cause),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // First matching window in table order decides the slave; -1 when unmapped.
    function automatic int ref_decode(input logic [31:0] a);
        for (int r = 0; r < 9; r++) begin
            if (((a ^ rgn_base[r]) & rgn_mask[r]) == 32'd0) return rgn_slv[r];
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(slv_valid), 32'd0);
        check({tag, "_ready"}, 32'(mst_ready), 32'd0);
        check({tag, "_rdata"}, mst_rdata, 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Runs one access; the target slave asserts ready on its (delay+1)-th valid cycle.
    task automatic run_access(input logic [31:0] addr, input logic [3:0] wstrb,
                              input logic [31:0] wdata, input int delay, input logic [31:0] rd);
        int tgt;
        int done_c;
        int valid_last;
        bit is_err;
        logic [31:0] exp_valid;
        logic [31:0] got_q;
        tgt = ref_decode(addr);
        if (tgt < 0) begin
            done_c = 1; is_err = 1'b1; valid_last = 0;
            exp_q.push_back(ERR_RD);
        end else if (delay < TMO) begin
            done_c = delay + 1; is_err = 1'b0; valid_last = done_c;
            exp_q.push_back(rd);
        end else begin
            done_c = TMO + 1; is_err = 1'b1; valid_last = TMO;
            exp_q.push_back(ERR_RD);
        end
        mst_valid = 1'b1;
        mst_addr  = addr;
        mst_wdata = wdata;
        mst_wstrb = wstrb;
        for (int c = 1; c <= done_c; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < SLV; k++) slv_rdata[32*k +: 32] = $urandom;
            slv_ready = SLV'($urandom);
            if (tgt >= 0) begin
                slv_rdata[32*tgt +: 32] = rd;
                slv_ready[tgt] = (c == delay + 1);
            end
            #1;
            exp_valid = (tgt >= 0 && c <= valid_last) ? (32'd1 << tgt) : 32'd0;
            check("slv_valid", 32'(slv_valid), exp_valid);
            if (c == 1) begin
                check("slv_addr", slv_addr, addr);
                check("slv_wdata", slv_wdata, wdata);
                check("slv_wstrb", 32'(slv_wstrb), 32'(wstrb));
            end
            check("mst_ready", 32'(mst_ready), 32'(c == done_c));
            check("err_pulse", 32'(err), 32'(c == done_c && is_err));
            if (c == done_c) begin
                got_q = exp_q.pop_front();
                check("rdata_done", mst_rdata, got_q);
            end else begin
                check("rdata_wait", mst_rdata, 32'd0);
            end
        end
        if (is_err) begin
            exp_err_addr  = addr;
            exp_err_cause = (tgt >= 0);
        end
        check("err_addr", err_addr, exp_err_addr);
        check("err_cause", 32'(err_cause), 32'(exp_err_cause));
        @(posedge clk); #1;
        mst_valid = 1'b0;
        slv_ready = SLV'($urandom);
        // After a timeout the aborted slave answers late; that must not complete anything.
        if (tgt >= 0 && is_err) slv_ready[tgt] = 1'b1;
        #1;
        check_idle("post");
        check("post_state", 32'(dbg_state), 32'd0);
        slv_ready = '0;
    endtask

    initial begin
        logic [31:0] a;
        int r;
        #2;
        check_idle("reset");
        check("reset_err_addr", err_addr, 32'd0);
        check("reset_err_cause", 32'(err_cause), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_access(32'h1000_1004, 4'h0, 32'h0, 0, 32'h1234_5678);
        run_access(32'h4000_0010, 4'hF, 32'hCAFE_0001, 5, 32'h0);
        run_access(32'h1000_4008, 4'hF, 32'hCAFE_0002, 5, 32'h0);
        run_access(32'h2000_0000, 4'h0, 32'h0, 0, 32'h0);
        run_access(32'h1000_6000, 4'h0, 32'h0, 1000, 32'h0);
        run_access(32'h1000_6010, 4'h0, 32'h0, TMO - 1, 32'hA5A5_0F0F);
        run_access(32'h1000_6020, 4'h3, 32'h55AA_55AA, TMO, 32'h0);

        // Asynchronous reset in the middle of a stalled access.
        mst_valid = 1'b1;
        mst_addr  = 32'h1000_3000;
        mst_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_err_addr", err_addr, 32'd0);
        check("async_rst_state", 32'(dbg_state), 32'd0);
        mst_valid = 1'b0;
        exp_err_addr  = '0;
        exp_err_cause = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_access(32'h1000_0008, 4'h0, 32'h0, 2, 32'h0BAD_F00D);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 8);
                a = rgn_base[r] | ($urandom & ~rgn_mask[r]);
            end else begin
                a = $urandom;
            end
            run_access(a, 4'($urandom), $urandom, $urandom_range(0, 20), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
